// File: rtl/mem_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mem_port_arbiter_pkg
//  Purpose  : Shared types and constants for the memory port arbiter.
//             - owner_e: which requester is owed read data in the next cycle.
//             - STARVE_LIMIT_DEFAULT: default number of consecutive
//               data-won conflicts allowed before fetch is granted.
//  Revision : 1.0  initial release
// ============================================================================
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_INST = 2'd1,
    OWN_DATA = 2'd2
  } owner_e;

  localparam int unsigned STARVE_LIMIT_DEFAULT = 4;
  localparam int unsigned STREAK_W             = 4;

endpackage
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_port_arbiter
//  Purpose  : Shares one SRAM-like port between instruction fetch and the MEM
//             stage. One grant per cycle (combinational), 1-cycle read data
//             routed back to the owner, stall request to the loser, and a
//             consecutive-win counter that bounds fetch starvation.
//  Ports    : clk, rst              clock / sync active-high reset
//             flush                 cancels in-flight fetch return
//             inst_req_*            fetch request; inst_rdata/inst_rvalid
//             data_req_*            load/store request; data_rdata/data_rvalid
//             sram_*                shared memory port
//             stallreq_if/_mem      requester not granted this cycle
//  Revision : 1.0  initial release
// ============================================================================
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        inst_req_en,
  input  logic [31:0] inst_req_addr,
  output logic [31:0] inst_rdata,
  output logic        inst_rvalid,
  input  logic        data_req_en,
  input  logic [3:0]  data_req_wen,
  input  logic [31:0] data_req_addr,
  input  logic [31:0] data_req_wdata,
  output logic [31:0] data_rdata,
  output logic        data_rvalid,
  output logic        sram_en,
  output logic [3:0]  sram_wen,
  output logic [31:0] sram_addr,
  output logic [31:0] sram_wdata,
  input  logic [31:0] sram_rdata,
  output logic        stallreq_if,
  output logic        stallreq_mem
);

  localparam logic [STREAK_W-1:0] C_LIMIT = STREAK_W'(STARVE_LIMIT);

  owner_e              owner_q, owner_d;
  logic [STREAK_W-1:0] streak_q, streak_d;
  logic                w_grant_inst;
  logic                w_grant_data;
  logic                w_conflict;

  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q  <= OWN_NONE;
      streak_q <= '0;
    end else begin
      owner_q  <= owner_d;
      streak_q <= streak_d;
    end
  end

  always_comb begin
    w_grant_inst = 1'b0;
    w_grant_data = 1'b0;
    w_conflict   = 1'b0;
    sram_en      = 1'b0;
    sram_wen     = 4'd0;
    sram_addr    = 32'd0;
    sram_wdata   = 32'd0;
    stallreq_if  = 1'b0;
    stallreq_mem = 1'b0;
    inst_rvalid  = 1'b0;
    inst_rdata   = 32'd0;
    data_rvalid  = 1'b0;
    data_rdata   = 32'd0;
    owner_d      = OWN_NONE;
    streak_d     = streak_q;

    // Everything is masked while reset is held so no access leaks out and
    // any return owed from before reset is dropped.
    if (!rst) begin
      w_conflict = inst_req_en & data_req_en;

      // Data wins conflicts until the streak hits the limit.
      if (inst_req_en && (!data_req_en || streak_q == C_LIMIT)) begin
        w_grant_inst = 1'b1;
      end else if (data_req_en) begin
        w_grant_data = 1'b1;
      end

      stallreq_if  = inst_req_en & ~w_grant_inst;
      stallreq_mem = data_req_en & ~w_grant_data;

      if (w_grant_inst) begin
        sram_en   = 1'b1;
        sram_addr = inst_req_addr;
        // A fetch flushed in its grant cycle is still issued but its data
        // will never be claimed.
        owner_d   = flush ? OWN_NONE : OWN_INST;
        streak_d  = '0;
      end else if (w_grant_data) begin
        sram_en    = 1'b1;
        sram_wen   = data_req_wen;
        sram_addr  = data_req_addr;
        sram_wdata = data_req_wdata;
        owner_d    = (data_req_wen == 4'd0) ? OWN_DATA : OWN_NONE;
        if (w_conflict && streak_q != C_LIMIT) begin
          streak_d = streak_q + 1'b1;
        end
      end

      // Return cycle of the access granted one cycle earlier.
      if (owner_q == OWN_INST && !flush) begin
        inst_rvalid = 1'b1;
        inst_rdata  = sram_rdata;
      end
      if (owner_q == OWN_DATA) begin
        data_rvalid = 1'b1;
        data_rdata  = sram_rdata;
      end
    end
  end

endmodule
`default_nettype wire
